// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for the pipelined N-bit ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_NOT   = 4'h5,
        OP_SHL   = 4'h6,
        OP_SHR   = 4'h7,
        OP_ADC   = 4'h8,
        OP_SBB   = 4'h9,
        OP_SAR   = 4'hA,
        OP_ROL   = 4'hB,
        OP_ROR   = 4'hC,
        OP_MUL   = 4'hD,
        OP_RSV_E = 4'hE,
        OP_RSV_F = 4'hF
    } alu_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done is high in the last iteration cycle; Product is valid while done is high.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 done,
    output logic [2*WIDTH-1:0]   Product
);

    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] partial;
    logic [WIDTH-1:0]   mplier;
    logic [SHW-1:0]     count;
    logic               busy;

    // Product includes the current iteration's partial so the final sum is
    // available on the same edge the last bit is consumed.
    assign partial = mplier[0] ? mcand : '0;
    assign Product = acc + partial;
    assign done    = busy && (count == SHW'(WIDTH - 1));

    // Iteration state: latch operands on start, then add/shift each cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= '0;
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
        end else if (busy) begin
            acc    <= Product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (done) begin
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_nbit_pipe.sv
// Registered N-bit ALU with valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, and the producer holds the offer
// (input side) / the result and flags (output side) stable until taken.
module alu_nbit_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Opcode,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Zero,
    output logic             Overflow,
    output logic             Negative,
    output logic             Illegal
);

    alu_state_e         state, state_next;
    alu_op_e            op;
    logic               accept, mul_start, mul_done, load_alu, load_mul, load;
    logic               cf;
    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0]        alu_res, ld_res;
    logic                    alu_c, alu_v, alu_ill, ld_c, ld_v, ld_ill;
    logic [WIDTH:0]          sum_w;
    logic signed [WIDTH:0]   sar_w;
    logic [2*WIDTH-1:0]      rot_w;

    assign op        = alu_op_e'(Opcode);
    assign amt       = B[SHW-1:0];
    assign In_ready  = !rst && (state == IDLE) && (!Out_valid || Out_ready);
    assign accept    = In_valid && In_ready;
    assign mul_start = accept && (op == OP_MUL);
    assign load_alu  = accept && (op != OP_MUL);
    assign load_mul  = (state == MUL) && mul_done;
    assign load      = load_alu || load_mul;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .A       (A),
        .B       (B),
        .done    (mul_done),
        .Product (product)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next state: stay in MUL until the multiplier reports done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_start) state_next = MUL;
            MUL:     if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Single-cycle datapath. Carry/borrow and shifted-out bits come from one
    // extra bit on the working vector; rotates use a doubled operand.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        sum_w   = '0;
        sar_w   = '0;
        rot_w   = '0;
        case (op)
            OP_ADD, OP_ADC: begin
                sum_w   = {1'b0, A} + {1'b0, B}
                        + {{WIDTH{1'b0}}, (op == OP_ADC) & cf};
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB, OP_SBB: begin
                sum_w   = {1'b0, A} - {1'b0, B}
                        - {{WIDTH{1'b0}}, (op == OP_SBB) & cf};
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (alu_res[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOT: alu_res = ~A;
            OP_SHL: begin
                sum_w   = {1'b0, A} << amt;
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
            end
            OP_SHR: begin
                sum_w   = {A, 1'b0} >> amt;
                alu_res = sum_w[WIDTH:1];
                alu_c   = sum_w[0];
            end
            OP_SAR: begin
                sar_w   = $signed({A, 1'b0}) >>> amt;
                alu_res = sar_w[WIDTH:1];
                alu_c   = sar_w[0];
            end
            OP_ROL: begin
                rot_w   = {A, A} << amt;
                alu_res = rot_w[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                rot_w   = {A, A} >> amt;
                alu_res = rot_w[WIDTH-1:0];
            end
            OP_MUL: alu_res = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // Select what enters the output register: multiplier result or datapath.
    always_comb begin
        ld_res = alu_res;
        ld_c   = alu_c;
        ld_v   = alu_v;
        ld_ill = alu_ill;
        if (load_mul) begin
            ld_res = product[WIDTH-1:0];
            ld_c   = |product[2*WIDTH-1:WIDTH];
            ld_v   = |product[2*WIDTH-1:WIDTH];
            ld_ill = 1'b0;
        end
    end

    // Output register and CF: load wins over take; take alone clears valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            Out_valid <= 1'b0;
            Result    <= '0;
            Carry     <= 1'b0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            Negative  <= 1'b0;
            Illegal   <= 1'b0;
            cf        <= 1'b0;
        end else if (load) begin
            Out_valid <= 1'b1;
            Result    <= ld_res;
            Carry     <= ld_c;
            Zero      <= (ld_res == '0);
            Overflow  <= ld_v;
            Negative  <= ld_res[WIDTH-1];
            Illegal   <= ld_ill;
            cf        <= ld_c;
        end else if (Out_valid && Out_ready) begin
            Out_valid <= 1'b0;
        end
    end

endmodule
